// File: rtl/wheel_velocity.sv
// +-----------------------------------------------------------------------------
// | Module      : wheel_velocity
// | Description : Mecanum inverse kinematics (vx, vy, wz) -> w1..w4 through one
// |               shared signed multiplier. Optional macro WHEEL_VELOCITY_SAT_FLAG_EN
// |               adds the WHEEL_VELOCITY_Sat_Out saturation flag.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module wheel_velocity #(
  parameter int DATAWIDTH_N  = 32,
  parameter int FRACTIONAL_Q = 15,
  parameter int INV_R        = 819200,
  parameter int K_LXLY       = 6554
) (
  input  logic                   WHEEL_VELOCITY_CLOCK_50,
  input  logic                   WHEEL_VELOCITY_Reset_InLow,
  input  logic                   WHEEL_VELOCITY_Start_In,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_VX_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_VY_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_WZ_InBus,
  output logic                   WHEEL_VELOCITY_Busy_Out,
  output logic                   WHEEL_VELOCITY_Done_Out,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W1_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W2_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W3_OutBus,
`ifdef WHEEL_VELOCITY_SAT_FLAG_EN
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W4_OutBus,
  output logic                   WHEEL_VELOCITY_Sat_Out
`else
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W4_OutBus
`endif
);

  localparam int c_PW = 2 * DATAWIDTH_N;
  localparam int c_SW = DATAWIDTH_N + 2;
  localparam logic signed [DATAWIDTH_N-1:0] c_MAX   = {1'b0, {(DATAWIDTH_N-1){1'b1}}};
  localparam logic signed [DATAWIDTH_N-1:0] c_MIN   = {1'b1, {(DATAWIDTH_N-1){1'b0}}};
  localparam logic signed [DATAWIDTH_N-1:0] c_INV_R = DATAWIDTH_N'(INV_R);
  localparam logic signed [DATAWIDTH_N-1:0] c_K     = DATAWIDTH_N'(K_LXLY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_K = 3'd1,
    S_SUM   = 3'd2,
    S_MUL1  = 3'd3,
    S_MUL2  = 3'd4,
    S_MUL3  = 3'd5,
    S_MUL4  = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic signed [DATAWIDTH_N-1:0] r_vx, r_vy, r_wz, r_a;
  logic signed [DATAWIDTH_N-1:0] r_s1, r_s2, r_s3, r_s4;
  logic signed [DATAWIDTH_N-1:0] r_t1, r_t2, r_t3;
  logic [DATAWIDTH_N-1:0]        r_w1, r_w2, r_w3, r_w4;
  logic                          r_busy, r_done;

  logic signed [DATAWIDTH_N-1:0] w_mul_a, w_mul_b, w_mul_sat;
  logic signed [c_PW-1:0]        w_prod, w_shift;
  logic                          w_mul_ovf;
  logic signed [c_SW-1:0]        w_sum1, w_sum2, w_sum3, w_sum4;
  logic                          w_sum_ovf;
  logic                          w_accept;

  function automatic logic sum_ovf(input logic signed [c_SW-1:0] s);
    return !((&s[c_SW-1:DATAWIDTH_N-1]) || !(|s[c_SW-1:DATAWIDTH_N-1]));
  endfunction

  function automatic logic [DATAWIDTH_N-1:0] sum_sat(input logic signed [c_SW-1:0] s);
    if (sum_ovf(s)) return s[c_SW-1] ? c_MIN : c_MAX;
    return s[DATAWIDTH_N-1:0];
  endfunction

  // The single multiplier: operand pair chosen by the current state.
  always_comb begin
    w_mul_a = r_wz;
    w_mul_b = c_K;
    case (r_state)
      S_MUL1:  begin w_mul_a = r_s1; w_mul_b = c_INV_R; end
      S_MUL2:  begin w_mul_a = r_s2; w_mul_b = c_INV_R; end
      S_MUL3:  begin w_mul_a = r_s3; w_mul_b = c_INV_R; end
      S_MUL4:  begin w_mul_a = r_s4; w_mul_b = c_INV_R; end
      default: ;
    endcase
  end

  assign w_prod    = c_PW'(w_mul_a) * c_PW'(w_mul_b);
  assign w_shift   = w_prod >>> FRACTIONAL_Q;
  assign w_mul_ovf = !((&w_shift[c_PW-1:DATAWIDTH_N-1]) || !(|w_shift[c_PW-1:DATAWIDTH_N-1]));
  assign w_mul_sat = w_mul_ovf ? (w_shift[c_PW-1] ? c_MIN : c_MAX) : w_shift[DATAWIDTH_N-1:0];

  assign w_sum1    = c_SW'(r_vx) - c_SW'(r_vy) - c_SW'(r_a);
  assign w_sum2    = c_SW'(r_vx) + c_SW'(r_vy) + c_SW'(r_a);
  assign w_sum3    = c_SW'(r_vx) + c_SW'(r_vy) - c_SW'(r_a);
  assign w_sum4    = c_SW'(r_vx) - c_SW'(r_vy) + c_SW'(r_a);
  assign w_sum_ovf = sum_ovf(w_sum1) | sum_ovf(w_sum2) | sum_ovf(w_sum3) | sum_ovf(w_sum4);

  assign w_accept  = (r_state == S_IDLE) && WHEEL_VELOCITY_Start_In;

  always_ff @(posedge WHEEL_VELOCITY_CLOCK_50) begin
    if (!WHEEL_VELOCITY_Reset_InLow) r_state <= S_IDLE;
    else                             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (WHEEL_VELOCITY_Start_In) w_next = S_MUL_K;
      S_MUL_K: w_next = S_SUM;
      S_SUM:   w_next = S_MUL1;
      S_MUL1:  w_next = S_MUL2;
      S_MUL2:  w_next = S_MUL3;
      S_MUL3:  w_next = S_MUL4;
      S_MUL4:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge WHEEL_VELOCITY_CLOCK_50) begin
    if (!WHEEL_VELOCITY_Reset_InLow) begin
      r_vx <= '0; r_vy <= '0; r_wz <= '0; r_a <= '0;
      r_s1 <= '0; r_s2 <= '0; r_s3 <= '0; r_s4 <= '0;
      r_t1 <= '0; r_t2 <= '0; r_t3 <= '0;
      r_w1 <= '0; r_w2 <= '0; r_w3 <= '0; r_w4 <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_vx   <= WHEEL_VELOCITY_VX_InBus;
          r_vy   <= WHEEL_VELOCITY_VY_InBus;
          r_wz   <= WHEEL_VELOCITY_WZ_InBus;
          r_busy <= 1'b1;
        end
        S_MUL_K: r_a  <= w_mul_sat;
        S_SUM: begin
          r_s1 <= sum_sat(w_sum1);
          r_s2 <= sum_sat(w_sum2);
          r_s3 <= sum_sat(w_sum3);
          r_s4 <= sum_sat(w_sum4);
        end
        S_MUL1:  r_t1 <= w_mul_sat;
        S_MUL2:  r_t2 <= w_mul_sat;
        S_MUL3:  r_t3 <= w_mul_sat;
        // All four outputs commit together so partial results are never visible.
        S_MUL4: begin
          r_w1   <= r_t1;
          r_w2   <= r_t2;
          r_w3   <= r_t3;
          r_w4   <= w_mul_sat;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef WHEEL_VELOCITY_SAT_FLAG_EN
  logic r_sat_sticky, r_sat_out;

  always_ff @(posedge WHEEL_VELOCITY_CLOCK_50) begin
    if (!WHEEL_VELOCITY_Reset_InLow) begin
      r_sat_sticky <= 1'b0;
      r_sat_out    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_sat_sticky <= 1'b0;
        S_SUM:   r_sat_sticky <= r_sat_sticky | w_sum_ovf;
        S_MUL4:  r_sat_out    <= r_sat_sticky | w_mul_ovf;
        default: r_sat_sticky <= r_sat_sticky | w_mul_ovf;
      endcase
    end
  end

  assign WHEEL_VELOCITY_Sat_Out = r_sat_out;
`endif

  assign WHEEL_VELOCITY_Busy_Out  = r_busy;
  assign WHEEL_VELOCITY_Done_Out  = r_done;
  assign WHEEL_VELOCITY_W1_OutBus = r_w1;
  assign WHEEL_VELOCITY_W2_OutBus = r_w2;
  assign WHEEL_VELOCITY_W3_OutBus = r_w3;
  assign WHEEL_VELOCITY_W4_OutBus = r_w4;

endmodule

`default_nettype wire

// File: tb/tb_wheel_velocity.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_wheel_velocity
// | Description : Directed vector bench for wheel_velocity.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_wheel_velocity;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] vx, vy, wz;
  logic        busy, done;
  logic [31:0] w1, w2, w3, w4;
  logic        sat;

  int n_cmp = 0;
  int n_err = 0;

  wheel_velocity dut (
    .WHEEL_VELOCITY_CLOCK_50    (clk),
    .WHEEL_VELOCITY_Reset_InLow (rst_n),
    .WHEEL_VELOCITY_Start_In    (start),
    .WHEEL_VELOCITY_VX_InBus    (vx),
    .WHEEL_VELOCITY_VY_InBus    (vy),
    .WHEEL_VELOCITY_WZ_InBus    (wz),
    .WHEEL_VELOCITY_Busy_Out    (busy),
    .WHEEL_VELOCITY_Done_Out    (done),
    .WHEEL_VELOCITY_W1_OutBus   (w1),
    .WHEEL_VELOCITY_W2_OutBus   (w2),
    .WHEEL_VELOCITY_W3_OutBus   (w3),
`ifdef WHEEL_VELOCITY_SAT_FLAG_EN
    .WHEEL_VELOCITY_Sat_Out     (sat),
`endif
    .WHEEL_VELOCITY_W4_OutBus   (w4)
  );

`ifndef WHEEL_VELOCITY_SAT_FLAG_EN
  assign sat = 1'b0;
`endif

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] vx, vy, wz;
    logic [31:0] w1, w2, w3, w4;
    logic        sat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    start = 1'b1; vx = a; vy = b; wz = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first falling edge after acceptance; returns cycles to Done.
  task automatic wait_done(input string name, output int cyc);
    chk({name, "_busy_hi"}, {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_busy_lo_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_w(input string name, input vec_t v);
    chk({name, "_w1"}, w1, v.w1);
    chk({name, "_w2"}, w2, v.w2);
    chk({name, "_w3"}, w3, v.w3);
    chk({name, "_w4"}, w4, v.w4);
`ifdef WHEEL_VELOCITY_SAT_FLAG_EN
    chk({name, "_sat"}, {31'd0, sat}, {31'd0, v.sat});
`endif
  endtask

  initial begin
    int cyc;
    // x*INV_R >>> 15 is exactly 25*x, since INV_R = 25 << 15.
    tbl[0] = '{"fwd",   32'd32768, 32'd0, 32'd0,
               32'd819200, 32'd819200, 32'd819200, 32'd819200, 1'b0};
    tbl[1] = '{"lat",   32'd0, 32'd32768, 32'd0,
               -32'sd819200, 32'd819200, 32'd819200, -32'sd819200, 1'b0};
    tbl[2] = '{"rot",   32'd0, 32'd0, 32'd32768,
               -32'sd163850, 32'd163850, -32'sd163850, 32'd163850, 1'b0};
    tbl[3] = '{"floor", 32'd0, 32'd0, 32'hFFFF_FFFF,
               32'd25, -32'sd25, 32'd25, -32'sd25, 1'b0};
    tbl[4] = '{"posmax", 32'h7FFF_FFFF, 32'd0, 32'd0,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    // A = floor(6554*-16384/32768) = -3277; sums 11469, 21299, 27853, 4915.
    tbl[5] = '{"mixed", 32'd16384, 32'd8192, -32'sd16384,
               32'd286725, 32'd532475, 32'd696325, 32'd122875, 1'b0};
    tbl[6] = '{"negsat", 32'h8000_0000, 32'd1, 32'd0,
               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};

    rst_n = 1'b0; start = 1'b0; vx = '0; vy = '0; wz = '0;
    repeat (3) @(negedge clk);
    chk("rst_w1", w1, 32'd0);
    chk("rst_w4", w4, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      pulse(tbl[i].vx, tbl[i].vy, tbl[i].wz);
      vx = 32'h1234_5678; vy = 32'h0BAD_F00D; wz = 32'h7777_0000;
      wait_done(tbl[i].name, cyc);
      chk({tbl[i].name, "_latency"}, cyc, 32'd7);
      chk_w(tbl[i].name, tbl[i]);
    end

    // Start three cycles into a computation is ignored.
    pulse(tbl[0].vx, tbl[0].vy, tbl[0].wz);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; vx = tbl[1].vx; vy = tbl[1].vy; wz = tbl[1].wz;
    @(negedge clk);
    start = 1'b0;
    cyc = 4;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignored_latency", cyc, 32'd7);
    chk_w("ignored", tbl[0]);
    // Start during the Done cycle is accepted.
    start = 1'b1; vx = tbl[1].vx; vy = tbl[1].vy; wz = tbl[1].wz;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_pulse_1cyc", {31'd0, done}, 32'd0);
    chk_w("b2b_hold", tbl[0]);
    wait_done("b2b", cyc);
    chk("b2b_latency", cyc, 32'd7);
    chk_w("b2b", tbl[1]);

    // Reset in the 4th busy cycle discards the computation.
    pulse(tbl[5].vx, tbl[5].vy, tbl[5].wz);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_w1", w1, 32'd0);
    chk("midrst_w2", w2, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    chk("midrst_no_done", cyc, 32'd0);

    // Start together with reset is dropped.
    rst_n = 1'b0; start = 1'b1; vx = tbl[0].vx; vy = '0; wz = '0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy}, 32'd0);

    pulse(tbl[2].vx, tbl[2].vy, tbl[2].wz);
    wait_done("fresh", cyc);
    chk("fresh_latency", cyc, 32'd7);
    chk_w("fresh", tbl[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wheel_velocity.md
Name: wheel_velocity

Overview:
- Inverse kinematics for the 4-wheel mecanum base: converts a commanded local velocity (vx, vy, wz) into the four wheel angular-velocity setpoints w1..w4.
- Sits between the motion planner and the per-wheel speed controllers. It is the counterpart of the local-velocity (forward kinematics) block.
- A single shared signed multiplier runs under a small FSM with a start/done handshake.
- All buses are 32-bit two's-complement fixed point with FRACTIONAL_Q fractional bits.

Parameters:
- DATAWIDTH_N, 32: bus width.
- FRACTIONAL_Q, 15: fractional bits on all buses and constants.
- INV_R, 819200: 1/wheel_radius in Q15 (25.0 /m).
- K_LXLY, 6554: (lx+ly) half-wheelbase sum in Q15 (0.2 m).

Ports:
- WHEEL_VELOCITY_CLOCK_50  in  1  system clock.
- WHEEL_VELOCITY_Reset_InLow  in  1  synchronous active-low reset.
- WHEEL_VELOCITY_Start_In  in  1  request pulse; operands sampled when accepted.
- WHEEL_VELOCITY_VX_InBus  in  32  vx, m/s.
- WHEEL_VELOCITY_VY_InBus  in  32  vy, m/s.
- WHEEL_VELOCITY_WZ_InBus  in  32  wz, rad/s.
- WHEEL_VELOCITY_Busy_Out  out  1  high while a computation is in flight.
- WHEEL_VELOCITY_Done_Out  out  1  one-cycle pulse when W1..W4 update.
- WHEEL_VELOCITY_W1_OutBus .. W4_OutBus  out  32 each  wheel speeds, rad/s.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: W1..W4 = 0, Busy = 0, Done = 0, FSM = IDLE. Internal operand and partial registers are cleared to 0.
- Equations, with A = K_LXLY*wz:
  - w1 = (vx - vy - A)*INV_R
  - w2 = (vx + vy + A)*INV_R
  - w3 = (vx + vy - A)*INV_R
  - w4 = (vx - vy + A)*INV_R
- Multiply rule: signed 32x32 -> 64-bit product, arithmetic shift right by FRACTIONAL_Q (floor), then saturate to [0x8000_0000, 0x7FFF_FFFF].
- Add rule: sums are formed at 34 bits, then saturated to 32 bits before the multiply.
- FSM states: IDLE -> MUL_K -> SUM -> MUL1 -> MUL2 -> MUL3 -> MUL4 -> IDLE.
  - IDLE: if Start = 1, latch VX/VY/WZ, set Busy = 1, go to MUL_K.
  - MUL_K: A <= sat(K_LXLY*wz >>> Q).
  - SUM: s1..s4 <= sat34to32 of the four sums.
  - MULn: wn_tmp <= sat(sn*INV_R >>> Q), one multiplier use per state.
  - Exit of MUL4: W1..W4 output registers load together. Done = 1 for one cycle, Busy = 0, return to IDLE.
- Latency: Start sampled on edge T means outputs change and Done = 1 in the cycle after edge T+6 (7 cycles after acceptance).
- Back-to-back: a new Start may be accepted in the cycle Done is high. Next Done follows 7 cycles later.
- Start while Busy = 1: ignored, no queueing. In-flight operands are unaffected.
- Input changes after acceptance: no effect on the current result.
- Outputs hold their last value between Done pulses. They never show partial results.
- Reset mid-computation: on the next edge, all outputs return to reset values and the computation is discarded. Done is not asserted.
- Start asserted together with reset low: reset wins and Start is dropped.

Optional Feature:
- Macro: WHEEL_VELOCITY_SAT_FLAG_EN.
- When defined:
  - Extra output port WHEEL_VELOCITY_Sat_Out, 1 bit, reset 0.
  - Set internally when any saturation occurs in MUL_K, SUM or MUL1..4 of the current computation.
  - Presented on Sat_Out, registered with W1..W4 at Done, and held until the next Done.
  - The internal sticky flag clears when a new Start is accepted.
- When undefined: port absent, saturation behaviour otherwise identical.

Test Plan:
- Pure forward: vx = 32768 (1.0), vy = 0, wz = 0 -> W1..W4 = 819200 each. Done exactly 7 cycles after Start. Busy high for those 7 cycles.
- Pure lateral: vy = 32768, vx = wz = 0 -> W1 = -819200, W2 = 819200, W3 = 819200, W4 = -819200.
- Pure rotation: wz = 32768 -> A = 6554, so W1 = -163850, W2 = 163850, W3 = -163850, W4 = 163850.
- Floor/saturation: wz = -1, vx = vy = 0 -> A = -1, so W1 = W3 = 25, W2 = W4 = -25. Then vx = 0x7FFF_FFFF, vy = wz = 0 -> all W = 0x7FFF_FFFF, and Sat_Out = 1 when the macro is defined.
- Handshake: Start pulsed again 3 cycles after an accepted Start with different operands -> ignored, results match the first operands. Start in the Done cycle -> accepted, second Done 7 cycles later.
- Reset mid-op: Reset_InLow = 0 in the 4th busy cycle -> next edge W1..W4 = 0, Busy = 0, no Done pulse. A fresh Start then completes normally.
